// File: rtl/pipe_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU and MDU op
// encodings, and the multiply/divide unit state type.
package pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [2:0] MDOP_NONE  = 3'b000;
    localparam logic [2:0] MDOP_MULT  = 3'b001;
    localparam logic [2:0] MDOP_MULTU = 3'b010;
    localparam logic [2:0] MDOP_DIV   = 3'b011;
    localparam logic [2:0] MDOP_DIVU  = 3'b100;
    localparam logic [2:0] MDOP_MFHI  = 3'b101;
    localparam logic [2:0] MDOP_MFLO  = 3'b110;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // True for the ops that occupy the iterative multiply/divide unit.
    function automatic logic mdIsStart(input logic [2:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
               (op == MDOP_DIV)  || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/pipeexe_if.sv
// Bundle of E-stage fields entering the execute stage and its results leaving
// it; the pipeline side is the master, the execute stage is the slave.
interface pipeexe_if;
    import pipe_pkg::*;

    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] eb;
    logic [XLEN-1:0] eimm;
    logic [XLEN-1:0] epc4;
    logic [4:0]      ern0;
    logic [3:0]      ealuc;
    logic            ealuimm;
    logic            eshift;
    logic            ejal;
    logic [2:0]      emdop;

    logic [XLEN-1:0] ealu;
    logic [4:0]      ern;
    logic            mdstall;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output ea, eb, eimm, epc4, ern0, ealuc, ealuimm, eshift, ejal, emdop,
        input  ealu, ern, mdstall, hi, lo
    );

    modport slave (
        input  ea, eb, eimm, epc4, ern0, ealuc, ealuimm, eshift, ejal, emdop,
        output ealu, ern, mdstall, hi, lo
    );

endinterface

// File: rtl/pipe_mdu.sv
// Iterative multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up into HI/LO.
module pipe_mdu
    import pipe_pkg::*;
(
    input  logic            clock,
    input  logic            resetn,
    input  logic [2:0]      mdop_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            mdstall_o
);

    mdu_state_e  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] rawA_q, rawA_d;
    logic        isDiv_q, isDiv_d;
    logic        negRes_q, negRes_d;
    logic        negRem_q, negRem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        start;
    logic        signedOp;
    logic        aNeg, bNeg;
    logic [31:0] aMag, bMag;
    logic [32:0] remShift;
    logic        divFits;
    logic [31:0] remNext;
    logic [63:0] accStep;
    logic [63:0] prodFix;
    logic [31:0] resHi, resLo;

    assign start    = (state_q == MDU_IDLE) && mdIsStart(mdop_i);
    assign signedOp = (mdop_i == MDOP_MULT) || (mdop_i == MDOP_DIV);
    assign aNeg     = signedOp && a_i[31];
    assign bNeg     = signedOp && b_i[31];
    assign aMag     = aNeg ? -a_i : a_i;
    assign bMag     = bNeg ? -b_i : b_i;

    // Accumulator is the product for multiply and {remainder, quotient} for divide.
    always_comb begin
        remShift = {acc_q[63:32], acc_q[31]};
        divFits  = remShift >= {1'b0, opnd_q};
        remNext  = divFits ? 32'(remShift - {1'b0, opnd_q}) : remShift[31:0];
        if (isDiv_q) begin
            accStep = {remNext, acc_q[30:0], divFits};
        end else begin
            accStep = acc_q + (opnd_q[0] ? mcand_q : 64'd0);
        end
    end

    // Division by zero bypasses fix-up and reports the raw dividend in HI.
    always_comb begin
        prodFix = negRes_q ? -accStep : accStep;
        resHi   = prodFix[63:32];
        resLo   = prodFix[31:0];
        if (isDiv_q) begin
            if (opnd_q == 32'd0) begin
                resHi = rawA_q;
                resLo = 32'hFFFF_FFFF;
            end else begin
                resHi = negRem_q ? -accStep[63:32] : accStep[63:32];
                resLo = negRes_q ? -accStep[31:0]  : accStep[31:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opnd_d   = opnd_q;
        rawA_d   = rawA_q;
        isDiv_d  = isDiv_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    isDiv_d  = (mdop_i == MDOP_DIV) || (mdop_i == MDOP_DIVU);
                    acc_d    = isDiv_d ? {32'd0, aMag} : 64'd0;
                    mcand_d  = {32'd0, aMag};
                    opnd_d   = bMag;
                    rawA_d   = a_i;
                    negRes_d = aNeg ^ bNeg;
                    negRem_d = aNeg;
                    count_d  = 5'd0;
                    state_d  = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                acc_d   = accStep;
                mcand_d = mcand_q << 1;
                opnd_d  = isDiv_q ? opnd_q : (opnd_q >> 1);
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    hi_d    = resHi;
                    lo_d    = resLo;
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= MDU_IDLE;
            count_q  <= 5'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            opnd_q   <= 32'd0;
            rawA_q   <= 32'd0;
            isDiv_q  <= 1'b0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opnd_q   <= opnd_d;
            rawA_q   <= rawA_d;
            isDiv_q  <= isDiv_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Reset gates the stall directly so upstream stages unfreeze immediately.
    assign mdstall_o = resetn & (start | (state_q == MDU_BUSY));
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: rtl/pipeexe.sv
// Execute stage: combinational ALU/jal result and destination select, plus the
// iterative multiply/divide unit whose stall freezes the upstream pipeline.
module pipeexe
    import pipe_pkg::*;
(
    input  logic     clock,
    input  logic     resetn,
    pipeexe_if.slave bus
);

    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [4:0]      shamt;
    logic [XLEN-1:0] aluRes;
    logic [XLEN-1:0] resultMux;
    logic [XLEN-1:0] mduHi;
    logic [XLEN-1:0] mduLo;
    logic            mduStall;

    assign opA   = bus.eshift ? {27'd0, bus.eimm[10:6]} : bus.ea;
    assign opB   = bus.ealuimm ? bus.eimm : bus.eb;
    assign shamt = opA[4:0];

    // The top ealuc bit only matters for telling sra from srl.
    always_comb begin
        aluRes = opA + opB;
        case (bus.ealuc[2:0])
            ALUC_ADD[2:0]: aluRes = opA + opB;
            ALUC_SUB[2:0]: aluRes = opA - opB;
            ALUC_AND[2:0]: aluRes = opA & opB;
            ALUC_OR[2:0]:  aluRes = opA | opB;
            ALUC_XOR[2:0]: aluRes = opA ^ opB;
            ALUC_LUI[2:0]: aluRes = {opB[15:0], 16'd0};
            ALUC_SLL[2:0]: aluRes = opB << shamt;
            ALUC_SRL[2:0]: begin
                if (bus.ealuc == ALUC_SRA) begin
                    aluRes = $signed(opB) >>> shamt;
                end else begin
                    aluRes = opB >> shamt;
                end
            end
            default: aluRes = opA + opB;
        endcase
    end

    always_comb begin
        resultMux = aluRes;
        if (bus.ejal) begin
            resultMux = bus.epc4 + 32'd4;
        end else if (bus.emdop == MDOP_MFHI) begin
            resultMux = mduHi;
        end else if (bus.emdop == MDOP_MFLO) begin
            resultMux = mduLo;
        end
    end

    pipe_mdu u_mdu (
        .clock     (clock),
        .resetn    (resetn),
        .mdop_i    (bus.emdop),
        .a_i       (bus.ea),
        .b_i       (bus.eb),
        .hi_o      (mduHi),
        .lo_o      (mduLo),
        .mdstall_o (mduStall)
    );

    assign bus.ealu    = resultMux;
    assign bus.ern     = bus.ejal ? 5'd31 : bus.ern0;
    assign bus.mdstall = mduStall;
    assign bus.hi      = mduHi;
    assign bus.lo      = mduLo;

endmodule

// File: tb/tb_pipeexe.sv
// Randomised scoreboard bench for the execute stage: the driver predicts each
// instruction's result with plain arithmetic, the monitor checks it as it leaves E.
module tb_pipeexe;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic instrValid = 1'b0;

    always #5 clock = ~clock;

    pipeexe_if bus ();

    pipeexe dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] ealu;
        logic [4:0]  ern;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] refAlu(input logic [3:0] aluc, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(a % 32);
        case (aluc)
            4'b0000, 4'b1000: return a + b;
            4'b0100, 4'b1100: return a - b;
            4'b0001, 4'b1001: return a & b;
            4'b0101, 4'b1101: return a | b;
            4'b0010, 4'b1010: return a ^ b;
            4'b0110, 4'b1110: return b * 32'h0001_0000;
            4'b0011:          return b << sh;
            4'b0111:          return b >> sh;
            4'b1111:          return 32'($signed(b) >>> sh);
            default:          return 32'd0;
        endcase
    endfunction

    task automatic refMdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic        [63:0] p;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); modelHi = p[63:32]; modelLo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; modelHi = p[63:32]; modelLo = p[31:0]; end
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    modelLo = 32'hFFFF_FFFF;
                    modelHi = a;
                end else if (op == 3'd3) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    modelLo = sq[31:0];
                    modelHi = sr[31:0];
                end else begin
                    modelLo = a / b;
                    modelHi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] ea, input logic [31:0] eb,
                                 input logic [31:0] eimm, input logic [31:0] epc4, input logic [4:0] ern0,
                                 input logic [3:0] ealuc, input logic ealuimm, input logic eshift,
                                 input logic ejal, input logic [2:0] emdop);
        exp_t        e;
        logic [31:0] a, b;
        int          guard;
        @(posedge clock);
        #1;
        bus.ea = ea; bus.eb = eb; bus.eimm = eimm; bus.epc4 = epc4; bus.ern0 = ern0;
        bus.ealuc = ealuc; bus.ealuimm = ealuimm; bus.eshift = eshift; bus.ejal = ejal; bus.emdop = emdop;
        instrValid = 1'b1;
        a = eshift ? ((eimm >> 6) & 32'h1F) : ea;
        b = ealuimm ? eimm : eb;
        e.name  = name;
        e.stall = 0;
        if (emdop >= 3'd1 && emdop <= 3'd4) begin
            refMdu(emdop, ea, eb);
            e.stall = 33;
        end
        if (ejal)               e.ealu = epc4 + 32'd4;
        else if (emdop == 3'd5) e.ealu = modelHi;
        else if (emdop == 3'd6) e.ealu = modelLo;
        else                    e.ealu = refAlu(ealuc, a, b);
        e.ern = ejal ? 5'd31 : ern0;
        e.hi  = modelHi;
        e.lo  = modelLo;
        expQ.push_back(e);
        guard = 0;
        @(negedge clock);
        while (bus.mdstall === 1'b1 && guard < 60) begin
            guard++;
            @(negedge clock);
        end
        if (guard >= 60) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: stall still high after %0d cycles, required release by 33", name, guard);
        end
    endtask

    // Monitor: pops one prediction each time an instruction leaves E.
    initial begin
        exp_t e;
        int   stallCnt;
        stallCnt = 0;
        forever begin
            @(negedge clock);
            if (!resetn || !instrValid) begin
                stallCnt = 0;
            end else if (bus.mdstall === 1'b1) begin
                stallCnt++;
            end else begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: ealu 0x%0h with no prediction pending", bus.ealu);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, "_ealu"},  64'(bus.ealu), 64'(e.ealu));
                    checkOutput({e.name, "_ern"},   64'(bus.ern),  64'(e.ern));
                    checkOutput({e.name, "_hi"},    64'(bus.hi),   64'(e.hi));
                    checkOutput({e.name, "_lo"},    64'(bus.lo),   64'(e.lo));
                    checkOutput({e.name, "_stall"}, 64'(stallCnt), 64'(e.stall));
                end
                stallCnt = 0;
            end
        end
    end

    logic [3:0] alucTab [9] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010,
                                4'b0110, 4'b0011, 4'b0111, 4'b1111};

    initial begin
        logic [31:0] ra, rb, rimm;
        logic [2:0]  op;
        int          kind;

        bus.ea = 32'd5; bus.eb = 32'd6; bus.eimm = 32'd0; bus.epc4 = 32'd0; bus.ern0 = 5'd3;
        bus.ealuc = 4'b0000; bus.ealuimm = 1'b0; bus.eshift = 1'b0; bus.ejal = 1'b0; bus.emdop = 3'd1;
        #12;
        checkOutput("reset_mdstall", 64'(bus.mdstall), 64'd0);
        checkOutput("reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("reset_lo", 64'(bus.lo), 64'd0);
        checkOutput("reset_ealu_follows", 64'(bus.ealu), 64'd11);
        bus.emdop = 3'd0;
        #1 resetn = 1'b1;

        applyStimulus("add", 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd2, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus("sra", 32'd0, 32'h8000_0000, 32'd4 << 6, 32'd0, 5'd4, 4'b1111, 1'b0, 1'b1, 1'b0, 3'd0);
        applyStimulus("jal", 32'd0, 32'd0, 32'd0, 32'h100, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0);
        applyStimulus("mult", 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd1);
        applyStimulus("mflo", 32'd0, 32'd0, 32'd0, 32'd0, 5'd8, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd6);
        applyStimulus("mfhi", 32'd0, 32'd0, 32'd0, 32'd0, 5'd9, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd5);
        applyStimulus("div", 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd3);
        applyStimulus("divu_zero", 32'd7, 32'd0, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd4);
        applyStimulus("div_zero_signed", 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd3);
        applyStimulus("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd3);
        applyStimulus("mult_b2b_1", 32'd123456, 32'hFFFF_0001, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd1);
        applyStimulus("mult_b2b_2", 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd1);
        applyStimulus("after_b2b", 32'd9, 32'd1, 32'd0, 32'd0, 5'd5, 4'b0100, 1'b0, 1'b0, 1'b0, 3'd0);

        // Abort a multiply part-way through with an asynchronous reset.
        @(posedge clock);
        #1;
        instrValid = 1'b0;
        bus.ea = 32'd12345; bus.eb = 32'd678; bus.emdop = 3'd1; bus.ejal = 1'b0;
        repeat (11) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midreset_mdstall", 64'(bus.mdstall), 64'd0);
        checkOutput("midreset_hi", 64'(bus.hi), 64'd0);
        checkOutput("midreset_lo", 64'(bus.lo), 64'd0);
        modelHi = 32'd0;
        modelLo = 32'd0;
        bus.emdop = 3'd0;
        @(negedge clock);
        resetn = 1'b1;
        applyStimulus("multu_after_reset", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd2);
        applyStimulus("mflo_after_reset", 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd6);

        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 9));
            ra   = $urandom;
            rb   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            rimm = $urandom;
            if (kind < 6) begin
                applyStimulus("rnd_alu", ra, rb, rimm, $urandom, 5'($urandom), alucTab[$urandom_range(0, 8)],
                              1'($urandom), 1'($urandom), 1'b0, 3'd0);
            end else if (kind == 6) begin
                applyStimulus("rnd_jal", ra, rb, rimm, $urandom, 5'($urandom), 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0);
            end else if (kind == 7) begin
                applyStimulus("rnd_mfhilo", ra, rb, rimm, $urandom, 5'($urandom), 4'b0000, 1'b0, 1'b0, 1'b0,
                              3'(5 + $urandom_range(0, 1)));
            end else begin
                op = 3'($urandom_range(1, 4));
                if ($urandom_range(0, 9) == 0) begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                applyStimulus("rnd_mdu", ra, rb, rimm, $urandom, 5'($urandom), 4'b0000, 1'b0, 1'b0, 1'b0, op);
            end
        end

        @(posedge clock);
        #1;
        instrValid = 1'b0;
        bus.emdop = 3'd0;
        repeat (3) @(posedge clock);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeexe.md
# pipeexe

Execute stage of the five-stage pipeline, directly downstream of the decode/execute pipeline register. Combinationally computes the ALU/jal result and the destination register from the E-stage fields, and hosts an iterative multiply/divide unit (MDU) with HI/LO registers. While a multiply or divide is in progress, it raises a stall that freezes the decode/execute register and all stages upstream of it.

## Interface
- XLEN, 32: datapath width. Only 32 is supported.
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- ea, eb  in  32  register operands
- eimm  in  32  extended immediate; the shift amount is eimm[10:6]
- epc4  in  32  PC+4 of the E-stage instruction
- ern0  in  5  decoded destination register
- ealuc  in  4  ALU op
- ealuimm, eshift, ejal  in  1  select imm as B, select shamt as A, jal
- emdop  in  3  MDU op: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mfhi, 110 mflo
- ealu  out  32  stage result to the E/M register
- ern  out  5  final destination register
- mdstall  out  1  hold the D/E register and upstream stages
- hi, lo  out  32  HI/LO contents (debug/visibility)

## Operation
- ALU operand A = eshift ? zero-extended eimm[10:6] : ea. Operand B = ealuimm ? eimm : eb.
- ALU ops by ealuc: x000 add, x100 sub, x001 and, x101 or, x010 xor, x110 lui (B<<16), 0011 sll, 0111 srl, 1111 sra. Shift amount is A[4:0], applied to B. add/sub wrap, with no overflow trap.
- Result priority:
  - ejal: ealu = epc4 + 4.
  - emdop 101: ealu = hi. emdop 110: ealu = lo.
  - Otherwise: ealu = ALU result.
- ern = ejal ? 31 : ern0.
- MDU state machine:
  - IDLE: when emdop is 001–100, mdstall goes high in the same cycle. On the clock edge, the MDU latches the operand magnitudes (absolute values for signed ops) and the sign flags, clears the 5-bit count, and moves to BUSY.
  - BUSY: performs one bit per cycle. Multiply uses shift-add into a 64-bit accumulator. Divide uses restoring division. count increments each cycle. At count==31 the edge writes hi/lo after sign fix-up and moves to DONE.
  - DONE: mdstall is low, so the mult/div instruction leaves E. emdop is ignored in this state. DONE always returns to IDLE on the next edge.
- mdstall = resetn & ((IDLE & emdop∈{001..100}) | BUSY).
- Result placement: mult/multu write hi:lo = 64-bit product. div/divu write lo = quotient and hi = remainder.
- Signed fix-up:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero: lo = 0xFFFFFFFF, hi = ea (raw dividend), with no signed fix-up. Latency is unchanged.
- Signed 0x80000000 / −1 gives lo = 0x80000000, hi = 0. This falls out naturally from the magnitude path and needs no special case.
- mfhi/mflo read the registered hi/lo.

## Timing
- ALU path, ealu and ern are combinational, with zero latency.
- A mult/div occupies E for 34 cycles: 1 start cycle, 32 BUSY cycles, 1 DONE cycle. mdstall is high for the first 33 of them.
- hi/lo are valid from the DONE cycle onward. An mfhi/mflo immediately following the mult/div enters E the cycle after DONE and reads the new value, with no extra interlock.
- Back-to-back mult/div: the second instruction starts from IDLE the cycle after DONE.
- Reset (asynchronous, may assert mid-operation): state = IDLE, count = 0, hi = lo = 0, mdstall = 0. The in-flight operation is discarded. ealu/ern follow their inputs even during reset.

## Structure
- Shared package pipe_pkg holds:
  - ALUC_* op encodings.
  - MDOP_* encodings.
  - The MDU state enum (IDLE/BUSY/DONE).
  - XLEN.
- Sub-module pipe_mdu contains the FSM, counter, accumulator, fix-up logic and hi/lo. It exports hi, lo and mdstall.
- The ALU, operand muxes and result mux stay in pipeexe.

## Test plan
- add: ea=5, eb=0xFFFFFFFF, ealuc=0000 → ealu=4. sra: eshift=1, eimm[10:6]=4, eb=0x80000000, ealuc=1111 → ealu=0xF8000000.
- jal: ejal=1, epc4=0x100, ern0=0 → ealu=0x104, ern=31, mdstall=0.
- mult: ea=−3, eb=7 → mdstall high for exactly 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB. A following mflo → ealu=0xFFFFFFEB.
- div: ea=−7, eb=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu: ea=7, eb=0 → lo=0xFFFFFFFF, hi=7.
- resetn pulsed low at BUSY count=10 → mdstall=0 immediately, hi=lo=0. The next multu 0xFFFFFFFF×2 completes normally with hi=1, lo=0xFFFFFFFE.
- Two consecutive mult ops → second start occurs the cycle after the first DONE, with no missed or duplicated start.
